// File: rtl/trap_pkg.sv
// Shared types and constants for the interrupt trap sequencer.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    TAKE,
    HANDLER,
    RETURN
  } trap_state_t;

  localparam int TRAP_SYNC_MIN = 2;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for one asynchronous IRQ level, followed by a rising-edge pulse.
module irq_sync
  import trap_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  if (SYNC_STAGES < TRAP_SYNC_MIN) begin : g_bad_stages
    $error("irq_sync: SYNC_STAGES must be at least TRAP_SYNC_MIN");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/trap_ctrl.sv
// Interrupt trap sequencer: latches synchronized IRQ edges, picks the lowest enabled index,
// and handshakes with the control FSM to emit one-cycle take/return pulses for the CSR file.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         irq,
  input  logic [NUM_SRC-1:0]         irq_mask,
  input  logic                       mie,
  input  logic                       mstatus,
  output logic                       int_req,
  input  logic                       int_ack,
  output logic [$clog2(NUM_SRC)-1:0] int_cause,
  output logic                       int_taken,
  input  logic                       mret,
  output logic                       int_ret,
  output logic                       in_handler
);

  localparam int CW = $clog2(NUM_SRC);

  trap_state_t        state, state_nxt;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clr;
  logic [CW-1:0]      sel;
  logic               enabled;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .level(irq[gi]),
      .rise (rise[gi])
    );
  end

  assign active  = pending & irq_mask;
  assign enabled = mie & mstatus & (|active);

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = CW'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state == TAKE) clr[int_cause] = 1'b1;
  end

  // A fresh edge overrides a same-cycle clear so no event is dropped.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      int_cause <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && enabled) int_cause <= sel;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enabled)   state_nxt = REQUEST;
        else if (mret) state_nxt = RETURN;
      end
      REQUEST: begin
        if (int_ack)       state_nxt = TAKE;
        else if (!enabled) state_nxt = IDLE;
      end
      TAKE:    state_nxt = HANDLER;
      HANDLER: if (mret) state_nxt = RETURN;
      RETURN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_req    = 1'b0;
    int_taken  = 1'b0;
    int_ret    = 1'b0;
    in_handler = 1'b0;
    case (state)
      REQUEST: int_req = 1'b1;
      TAKE: begin
        int_taken  = 1'b1;
        in_handler = 1'b1;
      end
      HANDLER: in_handler = 1'b1;
      RETURN: begin
        int_ret    = 1'b1;
        in_handler = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a cycle-level behavioural model.
module tb_trap_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq = 4'h0;
  logic [3:0] irq_mask = 4'h0;
  logic       mie = 1'b0;
  logic       mstatus = 1'b0;
  logic       int_ack = 1'b0;
  logic       mret = 1'b0;
  logic       int_req, int_taken, int_ret, in_handler;
  logic [1:0] int_cause;

  int n_checks = 0;
  int n_fail = 0;

  trap_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .irq_mask  (irq_mask),
    .mie       (mie),
    .mstatus   (mstatus),
    .int_req   (int_req),
    .int_ack   (int_ack),
    .int_cause (int_cause),
    .int_taken (int_taken),
    .mret      (mret),
    .int_ret   (int_ret),
    .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget);
    int k;
    k = 0;
    while (!int_req && k < budget) begin
      tick();
      k++;
    end
    chk("req_within_budget", int_req, 1'b1);
  endtask

  // Behavioural model. Phases: 0 idle, 1 requesting, 2 taking, 3 in handler, 4 returning.
  localparam int P_IDLE = 0, P_REQ = 1, P_TAKE = 2, P_HND = 3, P_RET = 4;
  logic [3:0] syncq[$];   // [0] = newest sampled irq, [1] = synchronized level, [2] = its previous value
  logic [3:0] m_pend;
  logic [1:0] m_cause;
  int         m_ph;
  bit         m_live = 1'b0;

  initial begin
    logic [3:0] edges, act;
    bit         en;
    int         low;
    syncq = '{4'h0, 4'h0, 4'h0};
    m_pend = 4'h0; m_cause = 2'd0; m_ph = P_IDLE;
    forever begin
      @(posedge clk);
      if (rst) begin
        syncq = '{4'h0, 4'h0, 4'h0};
        m_pend = 4'h0; m_cause = 2'd0; m_ph = P_IDLE; m_live = 1'b1;
      end else begin
        edges = syncq[1] & ~syncq[2];
        act = m_pend & irq_mask;
        en = mie && mstatus && (act != 4'h0);
        low = 0;
        while (low < 3 && !act[low]) low++;
        if (m_ph == P_TAKE) m_pend[m_cause] = 1'b0;
        case (m_ph)
          P_IDLE: if (en) begin m_ph = P_REQ; m_cause = 2'(low); end
                  else if (mret) m_ph = P_RET;
          P_REQ:  if (int_ack) m_ph = P_TAKE; else if (!en) m_ph = P_IDLE;
          P_TAKE: m_ph = P_HND;
          P_HND:  if (mret) m_ph = P_RET;
          default: m_ph = P_IDLE;
        endcase
        m_pend = m_pend | edges;
        syncq.push_front(irq);
        void'(syncq.pop_back());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("model_int_req",    int_req,    m_ph == P_REQ);
        chk("model_int_taken",  int_taken,  m_ph == P_TAKE);
        chk("model_int_ret",    int_ret,    m_ph == P_RET);
        chk("model_in_handler", in_handler, m_ph >= P_TAKE);
        chk("model_int_cause",  int_cause,  m_cause);
        chk("model_pending",    dut.pending, m_pend);
      end
    end
  end

  task automatic finish_handler();
    int_ack = 1'b1; tick(); int_ack = 1'b0; tick();
    mret = 1'b1; tick(); mret = 1'b0; tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_int_req", int_req, 1'b0);
    chk("reset_in_handler", in_handler, 1'b0);
    chk("reset_int_cause", int_cause, 2'd0);
    irq_mask = 4'hF; mie = 1'b1; mstatus = 1'b1;
    tick();

    // Latency: irq[2] rises in cycle 0, request visible in cycle 4, ack in 6, take in 7.
    irq = 4'b0100;
    tick(); chk("lat_c1_req", int_req, 1'b0);
    tick();
    tick(); chk("lat_c3_req", int_req, 1'b0);
    tick(); chk("lat_c4_req", int_req, 1'b1); chk("lat_c4_cause", int_cause, 2'd2);
    tick();
    tick(); int_ack = 1'b1;
    tick(); int_ack = 1'b0;
    chk("take_c7", int_taken, 1'b1); chk("hnd_c7", in_handler, 1'b1);
    tick(); chk("take_c8", int_taken, 1'b0); chk("pend2_cleared", dut.pending[2], 1'b0);
    chk("hnd_c8", in_handler, 1'b1);
    mret = 1'b1;
    tick(); mret = 1'b0; chk("ret_pulse", int_ret, 1'b1);
    tick(); chk("ret_once", int_ret, 1'b0); chk("hnd_done", in_handler, 1'b0);
    irq = 4'h0; repeat (6) tick();

    // Simultaneous irq[3] and irq[1]: 1 first, then 3 two cycles after the return pulse.
    irq = 4'b1010;
    wait_req(12); chk("prio_first", int_cause, 2'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0; tick();
    mret = 1'b1; tick(); mret = 1'b0; chk("prio_ret", int_ret, 1'b1);
    tick(); chk("prio_idle_req", int_req, 1'b0);
    tick(); chk("prio_second_req", int_req, 1'b1); chk("prio_second", int_cause, 2'd3);
    finish_handler();
    irq = 4'h0; repeat (6) tick();

    // Withdrawal when mie drops in REQUEST.
    irq = 4'b0001;
    wait_req(12);
    mie = 1'b0; tick();
    chk("wd_req", int_req, 1'b0); chk("wd_taken", int_taken, 1'b0);
    tick(); chk("wd_pend", dut.pending[0], 1'b1);
    mie = 1'b1; tick(); chk("wd_rereq", int_req, 1'b1); chk("wd_cause", int_cause, 2'd0);
    finish_handler();
    irq = 4'h0; repeat (6) tick();

    // No nesting: irq[0] arriving in the handler waits until after return.
    irq = 4'b0100;
    wait_req(12);
    int_ack = 1'b1; tick(); int_ack = 1'b0; tick();
    irq = 4'b0101; tick(); irq = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      tick(); chk("nest_no_req", int_req, 1'b0);
    end
    chk("nest_pend0", dut.pending[0], 1'b1);
    mret = 1'b1; tick(); mret = 1'b0; chk("nest_ret", int_ret, 1'b1);
    tick(); chk("nest_idle", int_req, 1'b0);
    tick(); chk("nest_req", int_req, 1'b1); chk("nest_cause", int_cause, 2'd0);
    finish_handler();
    irq = 4'h0; repeat (6) tick();

    // Software mret with nothing pending.
    mret = 1'b1; tick(); mret = 1'b0; chk("sw_ret", int_ret, 1'b1);
    tick(); chk("sw_ret_once", int_ret, 1'b0); chk("sw_idle_req", int_req, 1'b0);

    // Reset inside the handler, then a stray ack in IDLE.
    irq = 4'b0010;
    wait_req(12);
    int_ack = 1'b1; tick(); int_ack = 1'b0; tick();
    chk("rst_pre_hnd", in_handler, 1'b1);
    rst = 1'b1; irq = 4'h0; tick(); rst = 1'b0;
    chk("rst_hnd", in_handler, 1'b0); chk("rst_ret", int_ret, 1'b0);
    chk("rst_req", int_req, 1'b0); chk("rst_cause", int_cause, 2'd0);
    tick(); chk("rst_no_ret", int_ret, 1'b0);
    int_ack = 1'b1; tick(); int_ack = 1'b0; chk("stray_ack", int_taken, 1'b0);
    tick(); chk("stray_ack2", int_taken, 1'b0);

    // Randomized traffic, checked by the model process every cycle.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) irq[b] = ~irq[b];
      if ($urandom_range(49) == 0) irq_mask = 4'($urandom);
      if ($urandom_range(19) == 0) mie = ~mie;
      if ($urandom_range(19) == 0) mstatus = ~mstatus;
      if ($urandom_range(9) == 0) begin mie = 1'b1; mstatus = 1'b1; end
      int_ack = ($urandom_range(2) == 0);
      mret = ($urandom_range(7) == 0);
      rst = ($urandom_range(399) == 0);
      tick();
    end
    rst = 1'b0; int_ack = 1'b0; mret = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Interrupt trap sequencer for the multicycle RISC-V core. It is the initiating side of the CSR trap interface: it synchronizes and latches external interrupt requests, arbitrates among them, and handshakes with the control FSM at instruction boundaries. It generates the one-cycle `int_taken` / `int_ret` pulses that make the CSR file capture `mepc` and clear or set `mstatus`. It sits between the external IRQ pins, the control FSM and the CSR file.

## Interface
Reset is `rst`, synchronous, active-high; the clock is `clk`.

Parameters:
- `NUM_SRC`, default 4: number of external interrupt sources; index 0 has the highest priority.
- `SYNC_STAGES`, default 2: synchronizer flops per source (must be ≥ 2).

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `irq`  in  NUM_SRC: asynchronous level inputs; the rising edge is the event.
- `irq_mask`  in  NUM_SRC: per-source enable (1 = enabled).
- `mie`  in  1: global interrupt enable from the CSR file.
- `mstatus`  in  1: interrupt-enable status bit from the CSR file.
- `int_req`  out  1: request to the control FSM; held until acked or withdrawn.
- `int_ack`  in  1: control FSM accepts the request at an instruction boundary.
- `int_cause`  out  $clog2(NUM_SRC): index of the requested or serviced source.
- `int_taken`  out  1: one-cycle pulse to the CSR file (captures `mepc`, clears `mstatus`).
- `mret`  in  1: one-cycle pulse while an `mret` executes.
- `int_ret`  out  1: one-cycle pulse to the CSR file (sets `mstatus`).
- `in_handler`  out  1: high from TAKE until RETURN completes.

## Operation
- Per source: a SYNC_STAGES-flop synchronizer, then a rising-edge detector.
  - A detected edge sets `pending[i]`.
  - `pending[i]` is cleared only in TAKE, when `i == int_cause`.
  - If a set and a clear hit the same bit in the same cycle, the set wins, so no event is lost.
- `enabled = mie & mstatus & |(pending & irq_mask)`.
- `sel` is the lowest set index of `pending & irq_mask`.
- FSM states, with state held in a register:
  - IDLE:
    - if `enabled`, latch `int_cause <= sel` and go to REQUEST.
    - else if `mret`, go to RETURN. This covers a software `mret` with no trap taken; the pulse is still forwarded.
  - REQUEST: `int_req = 1`; `int_cause` is frozen.
    - `int_ack` → TAKE. Ack has priority over withdrawal in the same cycle.
    - else if `enabled` drops (`mie` or `mstatus` cleared, or the mask removed) → IDLE, request withdrawn.
  - TAKE: `int_taken = 1` for exactly one cycle; clear `pending[int_cause]` → HANDLER.
  - HANDLER: `in_handler = 1`. New pending bits still accumulate, but no request is raised (no nesting). `mret` → RETURN.
  - RETURN: `int_ret = 1` for exactly one cycle → IDLE. The request is re-evaluated in IDLE the next cycle.
- `int_ack` outside REQUEST is ignored. `mret` in REQUEST or TAKE is ignored.

## Timing
- Reset values: state IDLE, all synchronizer flops 0, edge history 0, `pending` 0, `int_req` 0, `int_cause` 0, `int_taken` 0, `int_ret` 0, `in_handler` 0.
- Reset mid-operation abandons any request or handler with no pulse emitted.
- All outputs are decoded from registered state only, with no combinational path from inputs.
- Latency of `irq` rise at cycle 0:
  - `pending` is set at the end of cycle SYNC_STAGES+1.
  - `int_req` is high at cycle SYNC_STAGES+2 (min 4 with defaults).
- `int_ack` at cycle N → `int_taken` high in cycle N+1 → `in_handler` high from N+1.
- `mret` at cycle M (in HANDLER or IDLE) → `int_ret` high in cycle M+1.
- Minimum time from the end of RETURN to the next `int_req` is 2 cycles (IDLE, then REQUEST).
- Edges closer together than one cycle after synchronization on the same source coalesce into one pending event.

## Structure
- Package `trap_pkg`:
  - state enum `trap_state_t` {IDLE, REQUEST, TAKE, HANDLER, RETURN};
  - constant `TRAP_SYNC_MIN = 2`.
- Sub-module `irq_sync`: parameterized SYNC_STAGES synchronizer plus rising-edge pulse, one instance per source via generate.
- Top level holds the pending vector, the priority encoder and the FSM.

## Test plan
- Reset, then raise `irq[2]` with mask 4'b1111, `mie=1`, `mstatus=1`:
  - `int_req` rises on cycle 4 with `int_cause=2`;
  - ack on cycle 6 → `int_taken` high only in cycle 7 and `pending[2]` cleared.
- `irq[3]` and `irq[1]` rise in the same cycle:
  - `int_cause=1` is serviced first;
  - after `mret` → `int_ret` pulse, IDLE, then `int_req` reappears with `int_cause=3`.
- While in REQUEST, drop `mie` before ack:
  - `int_req` falls the next cycle, with no `int_taken`;
  - restore `mie` → request re-raised and `pending[cause]` still set.
- While in HANDLER, pulse `irq[0]`:
  - no `int_req` until after the `int_ret` cycle, then `int_cause=0`.
- `mret` in IDLE with nothing pending → a single `int_ret` pulse one cycle later, and state returns to IDLE.
- Assert `rst` in HANDLER:
  - all outputs 0 next cycle, with no `int_ret`;
  - `int_ack` pulse during IDLE is ignored (no `int_taken`).
